// File: rtl/imem_port_arbiter_pkg.sv
// Shared constants and owner encoding for the instruction-ROM port arbiter.
// Used by the arbiter, its interface and the starvation counter.
package imem_pkg;

   localparam int IMEM_AW         = 5;
   localparam int IMEM_STARVE_MAX = 4;

   // Word index is taken from byte-address bits [AW+1:WORD_LSB]
   localparam int WORD_LSB  = 2;
   localparam int ADDR_W    = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DBG  = 2'd2
   } owner_t;

   // True when the byte address is misaligned or lies outside the 2^aw word ROM
   function automatic logic addr_is_bad(input logic [ADDR_W-1:0] addr, input int aw);
      logic [ADDR_W-1:0] keep_mask;
      keep_mask = ((ADDR_W'(1) << aw) - ADDR_W'(1)) << WORD_LSB;
      return |(addr & ~keep_mask);
   endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of the IF / DBG request ports, the ROM port and the error flag.
// The arbiter uses the slave modport; the requesters/ROM side uses master.
interface imem_port_arbiter_if
   import imem_pkg::*;
#(
   parameter int AW = IMEM_AW
) ();

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [31:0]       if_rdata;

   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_gnt;
   logic              dbg_valid;
   logic [31:0]       dbg_rdata;

   logic [AW-1:0]     rom_a;
   logic [31:0]       rom_spo;

   logic              err;

   modport slave (
      input  if_req, if_addr, dbg_req, dbg_addr, rom_spo,
      output if_gnt, if_valid, if_rdata,
      output dbg_gnt, dbg_valid, dbg_rdata,
      output rom_a, err
   );

   modport master (
      output if_req, if_addr, dbg_req, dbg_addr, rom_spo,
      input  if_gnt, if_valid, if_rdata,
      input  dbg_gnt, dbg_valid, dbg_rdata,
      input  rom_a, err
   );

endinterface

// File: rtl/imem_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the debug port lost arbitration.
// sat is high once the count reaches MAX; clr has priority over inc.
module imem_starve_counter #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int            CW   = $clog2(MAX + 1);
   localparam logic [CW-1:0] MAXV = CW'(MAX);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAXV)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign sat = (cnt == MAXV);

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the async-read instruction ROM between CPU fetch (IF) and debug (DBG).
// Optional sticky address check is compiled in with IMEM_ADDR_CHK_EN.
module imem_port_arbiter
   import imem_pkg::*;
#(
   parameter int AW         = IMEM_AW,
   parameter int STARVE_MAX = IMEM_STARVE_MAX
) (
   input  logic                clk,
   input  logic                rst_n,
   imem_port_arbiter_if.slave  bus
);

   logic              starve_sat;
   logic              starve_inc;
   logic              gnt_if;
   logic              gnt_dbg;
   owner_t            gnt_owner;
   logic [ADDR_W-1:0] gnt_addr;

   logic [AW-1:0]     rom_a_q;
   owner_t            owner_q;
   logic              if_valid_q;
   logic              dbg_valid_q;
   logic [31:0]       if_rdata_q;
   logic [31:0]       dbg_rdata_q;
   logic              err_q;

   // IF wins ties unless DBG has already lost STARVE_MAX cycles in a row
   always_comb begin
      gnt_if    = 1'b0;
      gnt_dbg   = 1'b0;
      gnt_owner = OWN_NONE;
      gnt_addr  = bus.if_addr;
      if (bus.dbg_req && (!bus.if_req || starve_sat)) begin
         gnt_dbg   = 1'b1;
         gnt_owner = OWN_DBG;
         gnt_addr  = bus.dbg_addr;
      end else if (bus.if_req) begin
         gnt_if    = 1'b1;
         gnt_owner = OWN_IF;
      end
   end

   assign starve_inc = bus.dbg_req && !gnt_dbg;

   imem_starve_counter #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (starve_inc),
      .clr   (!starve_inc),
      .sat   (starve_sat)
   );

   // Address stage: rom_a only moves on a grant, so the ROM output stays quiet when idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_a_q <= '0;
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= gnt_owner;
         if (gnt_owner != OWN_NONE) begin
            rom_a_q <= gnt_addr[AW+WORD_LSB-1:WORD_LSB];
         end
      end
   end

   // Data stage: capture the async ROM output for whoever owned the previous address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid_q  <= 1'b0;
         dbg_valid_q <= 1'b0;
         if_rdata_q  <= '0;
         dbg_rdata_q <= '0;
      end else begin
         if_valid_q  <= (owner_q == OWN_IF);
         dbg_valid_q <= (owner_q == OWN_DBG);
         if (owner_q == OWN_IF) begin
            if_rdata_q <= bus.rom_spo;
         end
         if (owner_q == OWN_DBG) begin
            dbg_rdata_q <= bus.rom_spo;
         end
      end
   end

`ifdef IMEM_ADDR_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if ((gnt_owner != OWN_NONE) && addr_is_bad(gnt_addr, AW)) begin
         err_q <= 1'b1;
      end
   end
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^{gnt_addr[WORD_LSB-1:0], gnt_addr[ADDR_W-1:AW+WORD_LSB]};
   assign err_q = 1'b0;
`endif

   assign bus.if_gnt    = gnt_if;
   assign bus.dbg_gnt   = gnt_dbg;
   assign bus.rom_a     = rom_a_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.dbg_valid = dbg_valid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dbg_rdata = dbg_rdata_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vector table, reset/misalign sequences,
// then random traffic against a queue-based reference model. Honours IMEM_ADDR_CHK_EN.
module tb_imem_port_arbiter;
   import imem_pkg::*;

   localparam int AW = 5;
   localparam int SM = 4;
`ifdef IMEM_ADDR_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imem_port_arbiter_if #(.AW(AW)) bus ();

   imem_port_arbiter #(.AW(AW), .STARVE_MAX(SM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] rom_word(input int i);
      return 32'hA500_0000 | (32'(i) << 16) | (32'(i) * 32'h0000_1357);
   endfunction

   assign bus.rom_spo = rom_word(int'(bus.rom_a));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          ir;
      logic [31:0] ia;
      bit          dr;
      logic [31:0] da;
      bit          eig;
      bit          edg;
      int          era;
      bit          eiv;
      bit          edv;
      int          eidx;
      bit          eerr;
   } vec_t;

   typedef struct {
      owner_t own;
      int     idx;
      int     due;
   } pend_t;

   vec_t  tbl[11];
   pend_t q[$];

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 3) != 0) return 32'($urandom_range(0, 31)) * 32'd4;
      return $urandom();
   endfunction

   function automatic bit addr_bad(input logic [31:0] a);
      return ((a % 4) != 0) || ((a >> (AW + 2)) != 0);
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.if_req = 1'b0; bus.dbg_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      bit          ir, dr, ih, dh, eig, edg, ev_if, ev_dbg;
      logic [31:0] ia, da, last_if, last_dbg;
      int          starve, exp_ra, cyc;
      bit          exp_err;

      // directed traffic: IF stream, starvation of DBG, wrapped DBG address
      tbl[0]  = '{1, 32'h00, 0, 32'h00, 1, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 32'h04, 0, 32'h00, 1, 0, 1, 1, 0, 0, 0};
      tbl[2]  = '{1, 32'h08, 0, 32'h00, 1, 0, 2, 1, 0, 1, 0};
      tbl[3]  = '{1, 32'h0C, 1, 32'h84, 1, 0, 3, 1, 0, 2, 0};
      tbl[4]  = '{1, 32'h10, 1, 32'h84, 1, 0, 4, 1, 0, 3, 0};
      tbl[5]  = '{1, 32'h14, 1, 32'h84, 1, 0, 5, 1, 0, 4, 0};
      tbl[6]  = '{1, 32'h18, 1, 32'h84, 1, 0, 6, 1, 0, 5, 0};
      tbl[7]  = '{1, 32'h1C, 1, 32'h84, 0, 1, 1, 1, 0, 6, 1};
      tbl[8]  = '{1, 32'h1C, 1, 32'h10, 1, 0, 7, 0, 1, 1, 1};
      tbl[9]  = '{0, 32'h00, 0, 32'h00, 0, 0, 7, 1, 0, 7, 1};
      tbl[10] = '{0, 32'h00, 0, 32'h00, 0, 0, 7, 0, 0, 0, 1};

      bus.if_req = 1'b0; bus.if_addr = '0; bus.dbg_req = 1'b0; bus.dbg_addr = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst rom_a", 32'(bus.rom_a), 32'd0);
      chk("rst if_valid", 32'(bus.if_valid), 32'd0);
      chk("rst dbg_valid", 32'(bus.dbg_valid), 32'd0);
      chk("rst if_rdata", bus.if_rdata, 32'd0);
      chk("rst dbg_rdata", bus.dbg_rdata, 32'd0);
      chk("rst err", 32'(bus.err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         bus.if_req = tbl[i].ir; bus.if_addr = tbl[i].ia;
         bus.dbg_req = tbl[i].dr; bus.dbg_addr = tbl[i].da;
         #1;
         chk($sformatf("t%0d if_gnt", i), 32'(bus.if_gnt), 32'(tbl[i].eig));
         chk($sformatf("t%0d dbg_gnt", i), 32'(bus.dbg_gnt), 32'(tbl[i].edg));
         @(posedge clk); #1;
         chk($sformatf("t%0d rom_a", i), 32'(bus.rom_a), 32'(tbl[i].era));
         chk($sformatf("t%0d if_valid", i), 32'(bus.if_valid), 32'(tbl[i].eiv));
         chk($sformatf("t%0d dbg_valid", i), 32'(bus.dbg_valid), 32'(tbl[i].edv));
         if (tbl[i].eiv) chk($sformatf("t%0d if_rdata", i), bus.if_rdata, rom_word(tbl[i].eidx));
         if (tbl[i].edv) chk($sformatf("t%0d dbg_rdata", i), bus.dbg_rdata, rom_word(tbl[i].eidx));
         chk($sformatf("t%0d err", i), 32'(bus.err), 32'(CHK & tbl[i].eerr));
         @(negedge clk);
      end

      // reset asserted while a read is in flight
      bus.if_req = 1'b1; bus.if_addr = 32'h8;
      @(posedge clk); #1;
      bus.if_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid-rst rom_a", 32'(bus.rom_a), 32'd0);
      chk("mid-rst if_valid", 32'(bus.if_valid), 32'd0);
      chk("mid-rst if_rdata", bus.if_rdata, 32'd0);
      chk("mid-rst dbg_rdata", bus.dbg_rdata, 32'd0);
      chk("mid-rst err", 32'(bus.err), 32'd0);
      @(posedge clk); #1;
      chk("mid-rst no valid", 32'(bus.if_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post-rst idle valid", 32'(bus.if_valid | bus.dbg_valid), 32'd0);

      // misaligned fetch after release: wrapped word, err only with the check built in
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'h6;
      #1;
      chk("mis if_gnt", 32'(bus.if_gnt), 32'd1);
      @(posedge clk); #1;
      chk("mis rom_a", 32'(bus.rom_a), 32'd1);
      chk("mis err", 32'(bus.err), 32'(CHK));
      @(negedge clk);
      bus.if_req = 1'b0;
      @(posedge clk); #1;
      chk("mis if_valid", 32'(bus.if_valid), 32'd1);
      chk("mis if_rdata", bus.if_rdata, rom_word(1));

      // random traffic against the reference model
      apply_reset();
      starve = 0; exp_ra = 0; exp_err = 0; cyc = 0;
      last_if = '0; last_dbg = '0;
      ih = 0; dh = 0; ir = 0; dr = 0; ia = '0; da = '0;
      for (int k = 0; k < 400; k++) begin
         if (!ih) begin ir = ($urandom_range(0, 3) != 0); ia = rand_addr(); end
         if (!dh) begin dr = ($urandom_range(0, 1) != 0); da = rand_addr(); end
         bus.if_req = ir; bus.if_addr = ia; bus.dbg_req = dr; bus.dbg_addr = da;
         #1;
         edg = dr && (!ir || (starve >= SM));
         eig = ir && !edg;
         chk($sformatf("r%0d if_gnt", k), 32'(bus.if_gnt), 32'(eig));
         chk($sformatf("r%0d dbg_gnt", k), 32'(bus.dbg_gnt), 32'(edg));
         starve = (dr && !edg) ? ((starve + 1 > SM) ? SM : starve + 1) : 0;
         ih = ir && !eig;
         dh = dr && !edg;
         if (eig) begin
            q.push_back('{OWN_IF, int'((ia >> 2) % 32), cyc + 1});
            exp_ra = int'((ia >> 2) % 32);
            if (CHK && addr_bad(ia)) exp_err = 1;
         end else if (edg) begin
            q.push_back('{OWN_DBG, int'((da >> 2) % 32), cyc + 1});
            exp_ra = int'((da >> 2) % 32);
            if (CHK && addr_bad(da)) exp_err = 1;
         end
         @(posedge clk); #1;
         ev_if = 0; ev_dbg = 0;
         if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].own == OWN_IF) begin ev_if = 1; last_if = rom_word(q[0].idx); end
            else begin ev_dbg = 1; last_dbg = rom_word(q[0].idx); end
            void'(q.pop_front());
         end
         chk($sformatf("r%0d rom_a", k), 32'(bus.rom_a), 32'(exp_ra));
         chk($sformatf("r%0d if_valid", k), 32'(bus.if_valid), 32'(ev_if));
         chk($sformatf("r%0d dbg_valid", k), 32'(bus.dbg_valid), 32'(ev_dbg));
         chk($sformatf("r%0d if_rdata", k), bus.if_rdata, last_if);
         chk($sformatf("r%0d dbg_rdata", k), bus.dbg_rdata, last_dbg);
         chk($sformatf("r%0d err", k), 32'(bus.err), 32'(exp_err));
         cyc++;
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
